// File: rtl/controlador_atributos_param.sv
// Pet attribute controller: three saturating attributes updated once per
// prescaled tick from the one-hot activity state, plus a grace-period health FSM.
module controlador_atributos_param #(
   parameter int unsigned W           = 8,
   parameter int unsigned MAX_VAL     = 100,
   parameter int unsigned RATE_UP     = 7,
   parameter int unsigned RATE_DOWN   = 1,
   parameter int unsigned TICK_PERIOD = 50000000,
   parameter int unsigned LIMIAR      = 10,
   parameter int unsigned GRACE_TICKS = 3,
   parameter int unsigned INIT_FOME   = 80,
   parameter int unsigned INIT_FELIC  = 70,
   parameter int unsigned INIT_SONO   = 50
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   estado,
   output logic [W-1:0] fome,
   output logic [W-1:0] felicidade,
   output logic [W-1:0] sono,
   output logic         atualizou,
   output logic         alerta,
   output logic         morreu
);

   localparam int unsigned CntW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
   localparam int unsigned GrcW = $clog2(GRACE_TICKS + 1);

   localparam logic [CntW-1:0] CntLast   = CntW'(TICK_PERIOD - 1);
   localparam logic [W:0]      MaxE      = (W+1)'(MAX_VAL);
   localparam logic [W:0]      UpThrE    = (W+1)'(MAX_VAL - RATE_UP);
   localparam logic [W:0]      UpE       = (W+1)'(RATE_UP);
   localparam logic [W:0]      DnE       = (W+1)'(RATE_DOWN);
   localparam logic [W:0]      LimE      = (W+1)'(LIMIAR);
   localparam logic [GrcW:0]   GraceE    = (GrcW+1)'(GRACE_TICKS);

   typedef enum logic [1:0] {StVivo, StAlerta, StMorto} saude_e;

   // Saturating step up; arithmetic in W+1 bits so nothing wraps.
   function automatic logic [W-1:0] sobe(input logic [W-1:0] v);
      logic [W:0] e;
      e = {1'b0, v};
      if (e >= UpThrE) e = MaxE;
      else             e = e + UpE;
      return e[W-1:0];
   endfunction

   // Saturating step down towards zero.
   function automatic logic [W-1:0] desce(input logic [W-1:0] v);
      logic [W:0] e;
      e = {1'b0, v};
      if (e <= DnE) e = '0;
      else          e = e - DnE;
      return e[W-1:0];
   endfunction

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [GrcW-1:0] grace_q, grace_d;
   logic [W-1:0]    fome_q, fome_d, felic_q, felic_d, sono_q, sono_d;
   logic            atualizou_q, atualizou_d;
   saude_e          estado_q, estado_d;

   logic            tick;
   logic            crit;
   logic [GrcW:0]   grace_inc;

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         grace_q     <= '0;
         fome_q      <= W'(INIT_FOME);
         felic_q     <= W'(INIT_FELIC);
         sono_q      <= W'(INIT_SONO);
         atualizou_q <= 1'b0;
         estado_q    <= StVivo;
      end else begin
         cnt_q       <= cnt_d;
         grace_q     <= grace_d;
         fome_q      <= fome_d;
         felic_q     <= felic_d;
         sono_q      <= sono_d;
         atualizou_q <= atualizou_d;
         estado_q    <= estado_d;
      end
   end

   // Prescaler, attribute update and health FSM next-state.
   always_comb begin
      cnt_d       = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
      tick        = (cnt_q == CntLast) && (estado_q != StMorto);
      fome_d      = fome_q;
      felic_d     = felic_q;
      sono_d      = sono_q;
      grace_d     = grace_q;
      estado_d    = estado_q;
      atualizou_d = tick;
      crit        = 1'b0;
      grace_inc   = {1'b0, grace_q} + (GrcW+1)'(1);

      if (tick) begin
         case (estado)
            4'b0001: begin
               sono_d  = sobe(sono_q);
               fome_d  = desce(fome_q);
               felic_d = desce(felic_q);
            end
            4'b0010: begin
               fome_d  = sobe(fome_q);
               felic_d = desce(felic_q);
            end
            4'b0100: begin
               felic_d = sobe(felic_q);
            end
            default: begin
               fome_d  = desce(fome_q);
               felic_d = desce(felic_q);
               sono_d  = desce(sono_q);
            end
         endcase

         // Health is judged on the values being written this edge.
         crit = ({1'b0, fome_d} <= LimE) || ({1'b0, felic_d} <= LimE) ||
                ({1'b0, sono_d} <= LimE);

         if (!crit) begin
            grace_d  = '0;
            estado_d = StVivo;
         end else if (grace_inc >= GraceE) begin
            estado_d = StMorto;
         end else begin
            grace_d  = grace_inc[GrcW-1:0];
            estado_d = StAlerta;
         end
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      fome       = fome_q;
      felicidade = felic_q;
      sono       = sono_q;
      atualizou  = atualizou_q;
      alerta     = (estado_q == StAlerta);
      morreu     = (estado_q == StMorto);
   end

endmodule

// File: tb/tb_controlador_atributos_param.sv
// Directed, table-driven bench: two instances (default inits and low-fome/high-sono inits)
// share clock, reset and activity input; each table row selects which one it checks.
module tb_controlador_atributos_param;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] estado;

   logic [7:0] fome_a, felic_a, sono_a, fome_b, felic_b, sono_b;
   logic       atu_a, al_a, mo_a, atu_b, al_b, mo_b;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   controlador_atributos_param #(.TICK_PERIOD(4)) u_dut_a (
      .clk        (clk),
      .rst        (rst),
      .estado     (estado),
      .fome       (fome_a),
      .felicidade (felic_a),
      .sono       (sono_a),
      .atualizou  (atu_a),
      .alerta     (al_a),
      .morreu     (mo_a)
   );

   controlador_atributos_param #(.TICK_PERIOD(4), .INIT_FOME(12), .INIT_SONO(95)) u_dut_b (
      .clk        (clk),
      .rst        (rst),
      .estado     (estado),
      .fome       (fome_b),
      .felicidade (felic_b),
      .sono       (sono_b),
      .atualizou  (atu_b),
      .alerta     (al_b),
      .morreu     (mo_b)
   );

   typedef struct {
      logic       sel;     // 0: instance a, 1: instance b
      logic       do_rst;
      logic [3:0] est;
      int         f;
      int         h;
      int         s;
      logic       al;
      logic       mo;
   } vec_t;

   localparam int NVec = 25;
   vec_t vecs [NVec];

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      // Instance a: defaults 80/70/50.
      vecs[0]  = '{1'b0, 1'b1, 4'b0001, 79, 69, 57, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 4'b0010, 87, 69, 50, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 4'b0011, 86, 68, 49, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 4'b0100, 86, 75, 49, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 4'b1000, 85, 74, 48, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 4'b0100, 85, 81, 48, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 4'b0001, 84, 80, 55, 1'b0, 1'b0};
      // Instance b: 12/70/95 -- sono saturation, then decay to death.
      vecs[7]  = '{1'b1, 1'b1, 4'b0001, 11, 69, 100, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 4'b0001, 10, 68, 100, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, 4'b0000, 11, 69, 94, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 4'b0000, 10, 68, 93, 1'b1, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 4'b0000, 9, 67, 92, 1'b1, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 4'b0000, 8, 66, 91, 1'b0, 1'b1};
      // Instance b: recovery from alert clears grace, full grace needed again.
      vecs[13] = '{1'b1, 1'b1, 4'b0000, 11, 69, 94, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 4'b0000, 10, 68, 93, 1'b1, 1'b0};
      vecs[15] = '{1'b1, 1'b0, 4'b0010, 17, 67, 93, 1'b0, 1'b0};
      vecs[16] = '{1'b1, 1'b0, 4'b0000, 16, 66, 92, 1'b0, 1'b0};
      vecs[17] = '{1'b1, 1'b0, 4'b0000, 15, 65, 91, 1'b0, 1'b0};
      vecs[18] = '{1'b1, 1'b0, 4'b0000, 14, 64, 90, 1'b0, 1'b0};
      vecs[19] = '{1'b1, 1'b0, 4'b0000, 13, 63, 89, 1'b0, 1'b0};
      vecs[20] = '{1'b1, 1'b0, 4'b0000, 12, 62, 88, 1'b0, 1'b0};
      vecs[21] = '{1'b1, 1'b0, 4'b0000, 11, 61, 87, 1'b0, 1'b0};
      vecs[22] = '{1'b1, 1'b0, 4'b0000, 10, 60, 86, 1'b1, 1'b0};
      vecs[23] = '{1'b1, 1'b0, 4'b0000, 9, 59, 85, 1'b1, 1'b0};
      vecs[24] = '{1'b1, 1'b0, 4'b0000, 8, 58, 84, 1'b0, 1'b1};

      rst    = 1'b1;
      estado = 4'b0000;
      repeat (2) @(negedge clk);

      chk("rst fome_a", int'(fome_a), 80);
      chk("rst felic_a", int'(felic_a), 70);
      chk("rst sono_a", int'(sono_a), 50);
      chk("rst atualizou_a", int'(atu_a), 0);
      chk("rst alerta_a", int'(al_a), 0);
      chk("rst morreu_a", int'(mo_a), 0);
      chk("rst fome_b", int'(fome_b), 12);
      chk("rst sono_b", int'(sono_b), 95);
      rst = 1'b0;

      for (int i = 0; i < NVec; i++) begin
         logic [7:0] f, h, s;
         logic       atu, al, mo;
         if (vecs[i].do_rst) pulse_rst();
         estado = vecs[i].est;
         @(negedge clk);
         atu = vecs[i].sel ? atu_b : atu_a;
         chk($sformatf("v%0d atualizou low", i), int'(atu), 0);
         repeat (3) @(negedge clk);
         f   = vecs[i].sel ? fome_b  : fome_a;
         h   = vecs[i].sel ? felic_b : felic_a;
         s   = vecs[i].sel ? sono_b  : sono_a;
         atu = vecs[i].sel ? atu_b   : atu_a;
         al  = vecs[i].sel ? al_b    : al_a;
         mo  = vecs[i].sel ? mo_b    : mo_a;
         chk($sformatf("v%0d fome", i), int'(f), vecs[i].f);
         chk($sformatf("v%0d felicidade", i), int'(h), vecs[i].h);
         chk($sformatf("v%0d sono", i), int'(s), vecs[i].s);
         chk($sformatf("v%0d atualizou", i), int'(atu), 1);
         chk($sformatf("v%0d alerta", i), int'(al), int'(vecs[i].al));
         chk($sformatf("v%0d morreu", i), int'(mo), int'(vecs[i].mo));
      end

      // Dead instance b: a full tick period with recovering activity changes nothing.
      estado = 4'b0010;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("morto atualizou c%0d", k), int'(atu_b), 0);
      end
      chk("morto fome", int'(fome_b), 8);
      chk("morto felicidade", int'(felic_b), 58);
      chk("morto sono", int'(sono_b), 84);
      chk("morto morreu", int'(mo_b), 1);

      // Reset mid-period (cnt=2) while b is dead: everything back to reset values.
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst2 fome_a", int'(fome_a), 80);
      chk("rst2 sono_a", int'(sono_a), 50);
      chk("rst2 atualizou_a", int'(atu_a), 0);
      chk("rst2 fome_b", int'(fome_b), 12);
      chk("rst2 morreu_b", int'(mo_b), 0);
      chk("rst2 alerta_b", int'(al_b), 0);
      rst    = 1'b0;
      estado = 4'b0001;

      // Tick realigned to the 4th edge after release.
      repeat (3) @(negedge clk);
      chk("realign early atualizou", int'(atu_a), 0);
      chk("realign early sono", int'(sono_a), 50);
      @(negedge clk);
      chk("realign atualizou", int'(atu_a), 1);
      chk("realign sono_a", int'(sono_a), 57);
      chk("realign fome_a", int'(fome_a), 79);
      chk("realign fome_b", int'(fome_b), 11);
      chk("realign sono_b", int'(sono_b), 100);
      @(negedge clk);
      chk("realign pulse end", int'(atu_a), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
